// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command sequencer for a combinational ALU, with an accumulator feeding ALU B.
// Define ALU_OP_SEQUENCER_OVF_EN to add the ovf output (carry out of an add).
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_b,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_func,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic               cmd_clr,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0]   acc
`ifdef ALU_OP_SEQUENCER_OVF_EN
  ,
  output logic               ovf
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state;
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_data;
            alu_func  <= cmd_func;
            alu_b     <= cmd_clr ? '0 : acc;
            acc       <= cmd_clr ? '0 : acc;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_data  <= alu_result;
          acc       <= alu_result[WIDTH-1:0];
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // cmd_ready rises with the return to IDLE so the next command can be taken at once
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_OP_SEQUENCER_OVF_EN
  always_ff @(posedge Clock) begin
    if (!Reset_b) ovf <= 1'b0;
    else if (state == CAPTURE) ovf <= (alu_func == 2'd0) && (|alu_result[2*WIDTH-1:WIDTH]);
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
  logic       Clock, Reset_b, cmd_valid, cmd_ready, cmd_clr, rsp_valid, rsp_ready;
  logic [1:0] cmd_func, alu_func;
  logic [3:0] cmd_data, alu_a, alu_b, acc;
  logic [7:0] alu_result, rsp_data;
`ifdef ALU_OP_SEQUENCER_OVF_EN
  logic ovf;
`endif
  int checks = 0, failures = 0;
  logic [3:0] m_acc = 4'h0;
  logic [8:0] exp_q[$];

  alu_op_sequencer #(.WIDTH(4)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_data(cmd_data), .cmd_clr(cmd_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .acc(acc)
`ifdef ALU_OP_SEQUENCER_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic logic [7:0] alu_ref(input logic [1:0] f, input logic [3:0] a, input logic [3:0] b);
    return f == 2'd0 ? {4'h0, a} + {4'h0, b} :
           f == 2'd1 ? {7'h0, |{a, b}} :
           f == 2'd2 ? {7'h0, &{a, b}} : {a, b};
  endfunction

  always_comb alu_result = alu_ref(alu_func, alu_a, alu_b);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stall>0 holds rsp_ready low that many cycles while presenting a competing command (func 0, data 4)
  task automatic do_op(input logic [1:0] f, input logic [3:0] d, input logic c, input int stall);
    logic [3:0] b;
    logic [7:0] r;
    logic [8:0] e;
    int n;
    b = c ? 4'h0 : m_acc;
    r = alu_ref(f, d, b);
    m_acc = r[3:0];
    exp_q.push_back({(f == 2'd0) && (|r[7:4]), r});
    cmd_valid = 1'b1; cmd_func = f; cmd_data = d; cmd_clr = c;
    rsp_ready = (stall == 0);
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge Clock); #1; n++; end
    check("cmd_ready", cmd_ready, 1);
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
    check("alu_a", alu_a, d);
    check("alu_b", alu_b, b);
    check("alu_func", alu_func, f);
    n = 1;
    while (!rsp_valid && n < 10) begin @(posedge Clock); #1; n++; end
    check("latency", n, 3);
    for (int k = 0; k < stall; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_q[0][7:0]);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_alu_a", alu_a, d);
      cmd_valid = 1'b1; cmd_func = 2'd0; cmd_data = 4'h4; cmd_clr = 1'b0;
      @(posedge Clock); #1;
    end
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    check("rsp_data", rsp_data, e[7:0]);
    check("acc", acc, m_acc);
`ifdef ALU_OP_SEQUENCER_OVF_EN
    check("ovf", ovf, e[8]);
`endif
    @(posedge Clock); #1;
    check("rsp_drop", rsp_valid, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    Reset_b = 1'b0; cmd_valid = 1'b0; cmd_func = 2'd0; cmd_data = 4'h0; cmd_clr = 1'b0; rsp_ready = 1'b1;
    repeat (2) begin @(posedge Clock); #1; end
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_acc", acc, 0);
    check("rst_alu", {alu_a, alu_b, alu_func}, 0);
    Reset_b = 1'b1;
    @(posedge Clock); #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_acc", acc, 0);
    check("rel_rsp_valid", rsp_valid, 0);

    do_op(2'd0, 4'h5, 1'b1, 0);
    do_op(2'd0, 4'h2, 1'b0, 0);
    do_op(2'd3, 4'hA, 1'b0, 0);
    do_op(2'd1, 4'h0, 1'b0, 0);
    do_op(2'd2, 4'h0, 1'b0, 0);
    do_op(2'd0, 4'h3, 1'b0, 5);
    do_op(2'd0, 4'h4, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, i % 3);

    cmd_valid = 1'b1; cmd_func = 2'd0; cmd_data = 4'h9; cmd_clr = 1'b0;
    for (int n = 0; n < 20 && !cmd_ready; n++) begin @(posedge Clock); #1; end
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
    @(posedge Clock); #1;
    Reset_b = 1'b0;
    @(posedge Clock); #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_acc", acc, 0);
    Reset_b = 1'b1;
    m_acc = 4'h0;
    seen = 1'b0;
    repeat (6) begin @(posedge Clock); #1; seen |= rsp_valid; end
    check("midrst_no_rsp", seen, 0);
    check("midrst_ready", cmd_ready, 1);
    do_op(2'd0, 4'h3, 1'b0, 0);

    do_op(2'd0, 4'h1, 1'b1, 0);
    do_op(2'd0, 4'hF, 1'b0, 0);
    do_op(2'd3, 4'h6, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
